// File: rtl/from_local_xy_pkg.sv
// Shared definitions for the XY local-to-mesh injector: direction codes,
// default packet field positions and the direction decode function.
package from_local_xy_pkg;

    localparam logic [1:0] DIR_E = 2'd0;
    localparam logic [1:0] DIR_W = 2'd1;
    localparam logic [1:0] DIR_N = 2'd2;
    localparam logic [1:0] DIR_S = 2'd3;

    localparam int DX_MSB_DEFAULT = 29;
    localparam int DX_LSB_DEFAULT = 21;
    localparam int DY_MSB_DEFAULT = 20;
    localparam int DY_LSB_DEFAULT = 12;

    // dx wins over dy; a zero offset loops back through the east port.
    function automatic logic [1:0] route_dir(input logic signed [31:0] dx,
                                             input logic signed [31:0] dy,
                                             input logic route_y);
        if (dx < 0) return DIR_W;
        if (dx > 0) return DIR_E;
        if (!route_y) return DIR_E;
        if (dy > 0) return DIR_N;
        if (dy < 0) return DIR_S;
        return DIR_E;
    endfunction

endpackage

// File: rtl/from_local_xy_if.sv
// Core-side write port and the four router-side FIFO read ports of from_local_xy.
interface from_local_xy_if #(
    parameter int PACKET_WIDTH = 30
);
    logic [PACKET_WIDTH-1:0] din;
    logic                    din_wen;
    logic                    din_full;
    logic                    overflow;

    logic                    ren_east, ren_west, ren_north, ren_south;
    logic [PACKET_WIDTH-1:0] dout_east, dout_west, dout_north, dout_south;
    logic                    empty_east, empty_west, empty_north, empty_south;
    logic                    full_east, full_west, full_north, full_south;

    modport master (
        output din, din_wen, ren_east, ren_west, ren_north, ren_south,
        input  din_full, overflow,
        input  dout_east, dout_west, dout_north, dout_south,
        input  empty_east, empty_west, empty_north, empty_south,
        input  full_east, full_west, full_north, full_south
    );

    modport slave (
        input  din, din_wen, ren_east, ren_west, ren_north, ren_south,
        output din_full, overflow,
        output dout_east, dout_west, dout_north, dout_south,
        output empty_east, empty_west, empty_north, empty_south,
        output full_east, full_west, full_north, full_south
    );
endinterface

// File: rtl/fifo_buffer.sv
// Synchronous FIFO with registered occupancy; full/empty derive from the count register.
module fifo_buffer #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] din,
    input  logic             ren,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr, do_rd;

    assign do_wr = wen && !full;
    assign do_rd = ren && !empty;
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign dout  = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
        end
    end
endmodule

// File: rtl/from_local_xy.sv
// Local-core injector: one-entry staging register steered by signed dx/dy into
// four direction FIFOs. Optional counters under FROM_LOCAL_XY_STATS_EN.
module from_local_xy
    import from_local_xy_pkg::*;
#(
    parameter int PACKET_WIDTH = 30,
    parameter int BUFFER_DEPTH = 4,
    parameter int DX_MSB       = DX_MSB_DEFAULT,
    parameter int DX_LSB       = DX_LSB_DEFAULT,
    parameter int DY_MSB       = DY_MSB_DEFAULT,
    parameter int DY_LSB       = DY_LSB_DEFAULT,
    parameter bit ROUTE_Y      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
`ifdef FROM_LOCAL_XY_STATS_EN
    input  logic        stat_clr,
    output logic [15:0] cnt_east,
    output logic [15:0] cnt_west,
    output logic [15:0] cnt_north,
    output logic [15:0] cnt_south,
    output logic [15:0] cnt_drop,
`endif
    from_local_xy_if.slave bus
);
    logic [PACKET_WIDTH-1:0] stage_q;
    logic                    stage_valid_q;
    logic                    overflow_q;
    logic [1:0]              dir;
    logic                    drain, accept, din_full, violation;
    logic [3:0]              fifo_wen, fifo_ren, fifo_empty, fifo_full;
    logic [PACKET_WIDTH-1:0] fifo_dout [4];

    assign dir = route_dir(32'($signed(stage_q[DX_MSB:DX_LSB])),
                           32'($signed(stage_q[DY_MSB:DY_LSB])), ROUTE_Y);

    assign drain     = stage_valid_q && !fifo_full[dir];
    assign din_full  = stage_valid_q && !drain;
    assign accept    = bus.din_wen && !din_full;
    assign violation = bus.din_wen && din_full;

    always_comb begin
        fifo_wen      = '0;
        fifo_wen[dir] = drain;
    end

    // Accept takes priority so a simultaneous drain refills the stage with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q       <= '0;
            stage_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            if (accept) begin
                stage_q       <= bus.din;
                stage_valid_q <= 1'b1;
            end else if (drain) begin
                stage_valid_q <= 1'b0;
            end
            if (violation) overflow_q <= 1'b1;
        end
    end

    assign fifo_ren = {bus.ren_south, bus.ren_north, bus.ren_west, bus.ren_east};

    for (genvar g = 0; g < 4; g++) begin : g_fifo
        fifo_buffer #(
            .WIDTH (PACKET_WIDTH),
            .DEPTH (BUFFER_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .wen   (fifo_wen[g]),
            .din   (stage_q),
            .ren   (fifo_ren[g]),
            .dout  (fifo_dout[g]),
            .empty (fifo_empty[g]),
            .full  (fifo_full[g])
        );
    end

    assign bus.din_full    = din_full;
    assign bus.overflow    = overflow_q;
    assign bus.dout_east   = fifo_dout[DIR_E];
    assign bus.dout_west   = fifo_dout[DIR_W];
    assign bus.dout_north  = fifo_dout[DIR_N];
    assign bus.dout_south  = fifo_dout[DIR_S];
    assign bus.empty_east  = fifo_empty[DIR_E];
    assign bus.empty_west  = fifo_empty[DIR_W];
    assign bus.empty_north = fifo_empty[DIR_N];
    assign bus.empty_south = fifo_empty[DIR_S];
    assign bus.full_east   = fifo_full[DIR_E];
    assign bus.full_west   = fifo_full[DIR_W];
    assign bus.full_north  = fifo_full[DIR_N];
    assign bus.full_south  = fifo_full[DIR_S];

`ifdef FROM_LOCAL_XY_STATS_EN
    logic [15:0] cnt_q [4];
    logic [15:0] drop_q;

    // Saturating counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            drop_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (fifo_wen[i] && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
            end
            if (violation && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        end
    end

    assign cnt_east  = cnt_q[DIR_E];
    assign cnt_west  = cnt_q[DIR_W];
    assign cnt_north = cnt_q[DIR_N];
    assign cnt_south = cnt_q[DIR_S];
    assign cnt_drop  = drop_q;
`endif
endmodule

// File: tb/tb_from_local_xy.sv
// Self-checking bench for from_local_xy: ROUTE_Y=1 and ROUTE_Y=0 instances side by side.
module tb_from_local_xy;
    localparam int PW = 30;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    from_local_xy_if #(.PACKET_WIDTH(PW)) b1 ();
    from_local_xy_if #(.PACKET_WIDTH(PW)) b0 ();

`ifdef FROM_LOCAL_XY_STATS_EN
    logic        stat_clr;
    logic [15:0] c1_e, c1_w, c1_n, c1_s, c1_d;
    logic [15:0] c0_e, c0_w, c0_n, c0_s, c0_d;
`endif

    from_local_xy #(.PACKET_WIDTH(PW), .BUFFER_DEPTH(4), .ROUTE_Y(1'b1)) dut1 (
        .clk       (clk),
        .rst       (rst),
`ifdef FROM_LOCAL_XY_STATS_EN
        .stat_clr  (stat_clr),
        .cnt_east  (c1_e),
        .cnt_west  (c1_w),
        .cnt_north (c1_n),
        .cnt_south (c1_s),
        .cnt_drop  (c1_d),
`endif
        .bus       (b1)
    );

    from_local_xy #(.PACKET_WIDTH(PW), .BUFFER_DEPTH(4), .ROUTE_Y(1'b0)) dut0 (
        .clk       (clk),
        .rst       (rst),
`ifdef FROM_LOCAL_XY_STATS_EN
        .stat_clr  (stat_clr),
        .cnt_east  (c0_e),
        .cnt_west  (c0_w),
        .cnt_north (c0_n),
        .cnt_south (c0_s),
        .cnt_drop  (c0_d),
`endif
        .bus       (b0)
    );

    logic [PW-1:0] sb_e[$], sb_w[$], sb_n[$], sb_s[$];

    task automatic sb_push(input int dir, input logic [PW-1:0] p);
        case (dir)
            0: sb_e.push_back(p);
            1: sb_w.push_back(p);
            2: sb_n.push_back(p);
            default: sb_s.push_back(p);
        endcase
    endtask

    task automatic sb_pop(input int dir, output logic [PW-1:0] p);
        p = 'x;
        case (dir)
            0: if (sb_e.size() > 0) p = sb_e.pop_front();
            1: if (sb_w.size() > 0) p = sb_w.pop_front();
            2: if (sb_n.size() > 0) p = sb_n.pop_front();
            default: if (sb_s.size() > 0) p = sb_s.pop_front();
        endcase
    endtask

    function automatic int sb_total();
        return sb_e.size() + sb_w.size() + sb_n.size() + sb_s.size();
    endfunction

    task automatic sb_clear();
        sb_e.delete();
        sb_w.delete();
        sb_n.delete();
        sb_s.delete();
    endtask

    function automatic logic [PW-1:0] mk(input int dx, input int dy, input int tag);
        logic [8:0]  x;
        logic [8:0]  y;
        logic [11:0] t;
        x = dx[8:0];
        y = dy[8:0];
        t = tag[11:0];
        return {x, y, t};
    endfunction

    // Reference decode written from the field layout, independent of the package.
    function automatic int exp_dir(input logic [PW-1:0] p, input bit ry);
        int dx, dy;
        dx = int'(p[29:21]) - (p[29] ? 512 : 0);
        dy = int'(p[20:12]) - (p[20] ? 512 : 0);
        if (dx < 0) return 1;
        if (dx > 0) return 0;
        if (!ry) return 0;
        if (dy > 0) return 2;
        if (dy < 0) return 3;
        return 0;
    endfunction

    function automatic logic [3:0] empties(input bit w);
        if (w) return {b1.empty_south, b1.empty_north, b1.empty_west, b1.empty_east};
        return {b0.empty_south, b0.empty_north, b0.empty_west, b0.empty_east};
    endfunction

    function automatic logic [3:0] fulls(input bit w);
        if (w) return {b1.full_south, b1.full_north, b1.full_west, b1.full_east};
        return {b0.full_south, b0.full_north, b0.full_west, b0.full_east};
    endfunction

    function automatic logic [9:0] status(input bit w);
        if (w) return {empties(1), fulls(1), b1.din_full, b1.overflow};
        return {empties(0), fulls(0), b0.din_full, b0.overflow};
    endfunction

    function automatic logic [PW-1:0] dout(input bit w, input int dir);
        if (w) begin
            case (dir)
                0: return b1.dout_east;
                1: return b1.dout_west;
                2: return b1.dout_north;
                default: return b1.dout_south;
            endcase
        end
        case (dir)
            0: return b0.dout_east;
            1: return b0.dout_west;
            2: return b0.dout_north;
            default: return b0.dout_south;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ren(input bit w, input logic [3:0] m);
        if (w) {b1.ren_south, b1.ren_north, b1.ren_west, b1.ren_east} = m;
        else   {b0.ren_south, b0.ren_north, b0.ren_west, b0.ren_east} = m;
    endtask

    task automatic send(input bit w, input logic [PW-1:0] p);
        if (w) begin b1.din = p; b1.din_wen = 1'b1; end
        else   begin b0.din = p; b0.din_wen = 1'b1; end
        tick();
        b1.din_wen = 1'b0;
        b0.din_wen = 1'b0;
    endtask

    task automatic pop(input bit w, input int dir, output logic [PW-1:0] d);
        logic [3:0] m;
        m = 4'b0001 << dir;
        d = dout(w, dir);
        set_ren(w, m);
        tick();
        set_ren(w, 4'b0000);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (status(1) !== 10'b1111_0000_00)
            $display("FAIL reset_xy: got %b want %b", status(1), 10'b1111_0000_00);
        checks++;
        if (status(0) !== 10'b1111_0000_00)
            $display("FAIL reset_legacy: got %b want %b", status(0), 10'b1111_0000_00);
        if (status(1) !== 10'b1111_0000_00) errors++;
        if (status(0) !== 10'b1111_0000_00) errors++;
        rst = 1'b0;
        sb_clear();
    endtask

    task automatic test_steering();
        int dxs[5] = '{3, -1, 0, 0, 0};
        int dys[5] = '{0, 5, 2, -4, 0};
        int want[5] = '{0, 1, 2, 3, 0};
        logic [PW-1:0] p, d, e;
        logic [3:0] m, exp_empty;
        for (int i = 0; i < 5; i++) begin
            p = mk(dxs[i], dys[i], 12'h100 + i);
            sb_push(want[i], p);
            send(1, p);
            checks++;
            if (empties(1) !== 4'hF) begin
                errors++;
                $display("FAIL steer_early_%0d: empties %b want 1111", i, empties(1));
            end
            tick();
            m = 4'b0001 << want[i];
            exp_empty = ~m;
            checks++;
            if (empties(1) !== exp_empty) begin
                errors++;
                $display("FAIL steer_dir_%0d: empties %b want %b", i, empties(1), exp_empty);
            end
            pop(1, want[i], d);
            sb_pop(want[i], e);
            checks++;
            if (d !== e) begin
                errors++;
                $display("FAIL steer_data_%0d: got %h want %h", i, d, e);
            end
        end
    endtask

    task automatic test_legacy();
        logic [PW-1:0] p1, p2, d, e;
        logic [3:0] em;
        logic ns_seen;
        ns_seen = 1'b0;
        p1 = mk(0, -4, 12'h201);
        p2 = mk(-256, 7, 12'h202);
        sb_push(0, p1);
        sb_push(1, p2);
        b0.din = p1; b0.din_wen = 1'b1;
        tick();
        em = empties(0); ns_seen |= ~em[2] | ~em[3];
        b0.din = p2;
        tick();
        b0.din_wen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            em = empties(0); ns_seen |= ~em[2] | ~em[3];
            tick();
        end
        checks++;
        if (empties(0) !== 4'b1100) begin
            errors++;
            $display("FAIL legacy_dir: empties %b want 1100", empties(0));
        end
        for (int dir = 0; dir < 2; dir++) begin
            pop(0, dir, d);
            em = empties(0); ns_seen |= ~em[2] | ~em[3];
            sb_pop(dir, e);
            checks++;
            if (d !== e) begin
                errors++;
                $display("FAIL legacy_data_%0d: got %h want %h", dir, d, e);
            end
        end
        checks++;
        if (ns_seen !== 1'b0) begin
            errors++;
            $display("FAIL legacy_ns_empty: nonempty seen %b want 0", ns_seen);
        end
    endtask

    task automatic fill_east(input int base);
        logic [PW-1:0] p;
        for (int k = 0; k < 5; k++) begin
            p = mk(1 + k, 0, base + k);
            sb_push(0, p);
            checks++;
            if (b1.din_full !== 1'b0) begin
                errors++;
                $display("FAIL fill_accept_%0d: din_full %b want 0", k, b1.din_full);
            end
            b1.din = p; b1.din_wen = 1'b1;
            tick();
        end
        b1.din_wen = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] d, e;
        fill_east(12'h300);
        checks++;
        if ({b1.full_east, b1.din_full, b1.overflow} !== 3'b110) begin
            errors++;
            $display("FAIL bp_full: full/din_full/ovf %b want 110",
                     {b1.full_east, b1.din_full, b1.overflow});
        end
        pop(1, 0, d);
        sb_pop(0, e);
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL bp_first: got %h want %h", d, e);
        end
        checks++;
        if (b1.din_full !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: din_full %b want 0", b1.din_full);
        end
        tick();
        checks++;
        if (b1.full_east !== 1'b1) begin
            errors++;
            $display("FAIL bp_refill: full_east %b want 1", b1.full_east);
        end
        for (int k = 0; k < 4; k++) begin
            pop(1, 0, d);
            sb_pop(0, e);
            checks++;
            if (d !== e) begin
                errors++;
                $display("FAIL bp_order_%0d: got %h want %h", k + 2, d, e);
            end
        end
        checks++;
        if (empties(1) !== 4'hF) begin
            errors++;
            $display("FAIL bp_drained: empties %b want 1111", empties(1));
        end
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] p, e;
        logic [3:0] em;
        int stalls, pops;
        stalls = 0;
        pops = 0;
        set_ren(1, 4'b0011);
        for (int c = 0; c < 28; c++) begin
            if (c < 20) begin
                p = mk((c % 2 == 1) ? -(c + 1) : (c + 1), 0, 12'h400 + c);
                sb_push(exp_dir(p, 1'b1), p);
                b1.din = p;
                b1.din_wen = 1'b1;
                if (b1.din_full !== 1'b0) stalls++;
            end else begin
                b1.din_wen = 1'b0;
            end
            em = empties(1);
            for (int dir = 0; dir < 2; dir++) begin
                if (em[dir] == 1'b0) begin
                    sb_pop(dir, e);
                    pops++;
                    checks++;
                    if (dout(1, dir) !== e) begin
                        errors++;
                        $display("FAIL b2b_data_c%0d_d%0d: got %h want %h", c, dir, dout(1, dir), e);
                    end
                end
            end
            tick();
        end
        set_ren(1, 4'b0000);
        checks++;
        if (stalls !== 0) begin
            errors++;
            $display("FAIL b2b_stall: din_full cycles %0d want 0", stalls);
        end
        checks++;
        if (pops !== 20 || sb_total() !== 0) begin
            errors++;
            $display("FAIL b2b_count: popped %0d left %0d want 20/0", pops, sb_total());
        end
    endtask

    task automatic test_overflow_reset();
        logic [PW-1:0] d, e, bad;
        logic [3:0] em;
        logic west_seen;
        west_seen = 1'b0;
        fill_east(12'h500);
        bad = mk(-5, 0, 12'hBAD);
        send(1, bad);
        checks++;
        if ({b1.overflow, b1.din_full} !== 2'b11) begin
            errors++;
            $display("FAIL ovf_flag: ovf/din_full %b want 11", {b1.overflow, b1.din_full});
        end
        for (int k = 0; k < 3; k++) begin
            em = empties(1); west_seen |= ~em[1];
            pop(1, 0, d);
            sb_pop(0, e);
            checks++;
            if (d !== e) begin
                errors++;
                $display("FAIL ovf_east_%0d: got %h want %h", k, d, e);
            end
        end
        tick();
        em = empties(1); west_seen |= ~em[1];
        checks++;
        if (west_seen !== 1'b0 || b1.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_discard: west_seen %b ovf %b want 0 1", west_seen, b1.overflow);
        end
        // Reset lands while a write is in flight and entries remain buffered.
        b1.din = mk(0, 3, 12'h5FF);
        b1.din_wen = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b1.din_wen = 1'b0;
        sb_clear();
        checks++;
        if (status(1) !== 10'b1111_0000_00) begin
            errors++;
            $display("FAIL mid_reset: got %b want %b", status(1), 10'b1111_0000_00);
        end
        tick();
        checks++;
        if (empties(1) !== 4'hF) begin
            errors++;
            $display("FAIL post_reset_empty: empties %b want 1111", empties(1));
        end
    endtask

`ifdef FROM_LOCAL_XY_STATS_EN
    task automatic test_stats();
        logic [PW-1:0] d;
        do_reset();
        for (int k = 0; k < 3; k++) send(1, mk(0, 1, 12'h600 + k));
        for (int k = 0; k < 5; k++) begin
            b1.din = mk(2, 0, 12'h610 + k);
            b1.din_wen = 1'b1;
            tick();
        end
        b1.din = mk(0, 1, 12'h6EE);
        tick();
        b1.din_wen = 1'b0;
        checks++;
        if ({c1_n, c1_d, c1_e} !== {16'd3, 16'd1, 16'd4}) begin
            errors++;
            $display("FAIL stats_pre: north %0d drop %0d east %0d want 3 1 4", c1_n, c1_d, c1_e);
        end
        pop(1, 0, d);
        send(1, mk(0, 1, 12'h6A0));
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        checks++;
        if ({c1_e, c1_w, c1_n, c1_s, c1_d} !== 80'd0) begin
            errors++;
            $display("FAIL stats_clr: e %0d w %0d n %0d s %0d drop %0d want 0",
                     c1_e, c1_w, c1_n, c1_s, c1_d);
        end
        do_reset();
    endtask
`endif

    initial begin
        rst = 1'b1;
        b1.din = '0; b1.din_wen = 1'b0;
        b0.din = '0; b0.din_wen = 1'b0;
        set_ren(1, 4'b0000);
        set_ren(0, 4'b0000);
`ifdef FROM_LOCAL_XY_STATS_EN
        stat_clr = 1'b0;
`endif
        test_reset();
        test_steering();
        test_legacy();
        test_backpressure();
        test_back_to_back();
        test_overflow_reset();
`ifdef FROM_LOCAL_XY_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/from_local_xy.md
Name: from_local_xy

Overview:
- Successor to the single-axis local-to-network injector.
- Accepts spike packets from the local core, one per cycle, through a one-entry staging register with backpressure.
- Steers each packet by the signed dx/dy fields into one of four per-direction FIFOs (east/west/north/south) read by the mesh router ports.
- A one-dimensional mode (ROUTE_Y=0) reproduces the east/west-only routing of the previous generation.

Parameters:
- PACKET_WIDTH, 30, packet bit width.
- BUFFER_DEPTH, 4, depth of each direction FIFO; power of 2, ≥2.
- DX_MSB, 29, MSB of signed dx field.
- DX_LSB, 21, LSB of signed dx field.
- DY_MSB, 20, MSB of signed dy field.
- DY_LSB, 12, LSB of signed dy field.
- ROUTE_Y, 1, 1 = route dx==0 packets on dy; 0 = dx==0 packets go east, north/south FIFOs never written.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  PACKET_WIDTH  packet from core.
- din_wen  in  1  core write strobe.
- din_full  out  1  core must not assert din_wen while high.
- overflow  out  1  sticky: din_wen seen while din_full.
- ren_east / ren_west / ren_north / ren_south  in  1 each  router pops head of that FIFO.
- dout_east / dout_west / dout_north / dout_south  out  PACKET_WIDTH each  FIFO heads.
- empty_east / empty_west / empty_north / empty_south  out  1 each.
- full_east / full_west / full_north / full_south  out  1 each.

Behaviour:
- Reset: stage_valid=0, overflow=0, all FIFOs emptied; empty_*=1, full_*=0, din_full=0; dout_* don't-care until the first write.
- Direction decode on stage_data, evaluated in this order:
  - dx<0 → west.
  - dx>0 → east.
  - dx==0 and ROUTE_Y=0 → east.
  - dx==0 and ROUTE_Y=1: dy>0 → north; dy<0 → south; dy==0 → east (local loop-back through the east port, matching the legacy dx==0 convention).
  - dx and dy are two's complement.
- Drain: drain = stage_valid && !full_<dir>. The target FIFO write enable equals drain. All other FIFO write enables are 0.
- Accept: accept = din_wen && !din_full. din_full = stage_valid && !drain (combinational). Sustained throughput is 1 packet/cycle while the target FIFO has space.
- Stage update on each edge:
  - If accept: stage_data<=din and stage_valid<=1.
  - Else if drain: stage_valid<=0.
  - Otherwise hold.
  - Simultaneous accept and drain replaces the stage contents with no bubble.
- Latency: packet accepted at edge k is written to its FIFO at edge k+1 at the earliest. empty_<dir> falls after edge k+1. A blocked stage holds indefinitely with no timeout.
- Violation: din_wen while din_full → packet discarded, stage unchanged, overflow<=1 (cleared only by rst).
- FIFO semantics (fifo_buffer):
  - Read pops the head on the edge.
  - ren on an empty FIFO is ignored.
  - Simultaneous read and write on a full FIFO is not credited in the same cycle: full is registered, so the stage stalls one cycle.
- Per-direction ordering is FIFO. No ordering guarantee across directions.
- rst mid-operation: the staged packet and all buffered packets are lost. Outputs return to reset values on the next edge.

Optional Feature:
- Macro FROM_LOCAL_XY_STATS_EN.
- When defined, adds the following ports:
  - stat_clr in 1.
  - cnt_east / cnt_west / cnt_north / cnt_south out 16 each.
  - cnt_drop out 16.
- Counter behaviour:
  - cnt_<dir> increments on each drain to that direction.
  - cnt_drop increments on each overflow event.
  - All counters saturate at 16'hFFFF.
  - rst or stat_clr zeroes them. stat_clr has priority over same-cycle increment.
- When undefined: the ports and logic are absent; the routing behaviour is identical.

Decomposition:
- Shared package holds:
  - Direction encoding localparams: DIR_E=0, DIR_W=1, DIR_N=2, DIR_S=3.
  - The default packet field positions (DX/DY MSB/LSB).
- Decode is a function in the package: route_dir(dx, dy, route_y) → 2-bit dir.
- Sub-module: reuse the existing fifo_buffer, instantiated 4× via generate. When ROUTE_Y=0, the north/south instances are still present but never written.
- Staging register and counters stay in the top module.

Test Plan:
- Basic steering:
  - Stimulus: ROUTE_Y=1; inject dx=+3/dy=0, dx=−1/dy=5, dx=0/dy=+2, dx=0/dy=−4, dx=0/dy=0.
  - Response: east, west, north, south, east respectively; each dout equals the injected packet; empty_* falls 2 edges after din_wen.
- Legacy mode:
  - Stimulus: ROUTE_Y=0; inject dx=0/dy=−4 and dx=−256.
  - Response: first packet to east, second to west; empty_north and empty_south stay 1 throughout.
- Backpressure:
  - Stimulus: DEPTH=4, ren_east=0; write 5 consecutive east packets.
  - Response: full_east after the 4th; din_full=1 with the 5th in the stage.
  - Then pulse ren_east once: the 5th packet drains within 2 cycles and din_full falls. Order on readout is 1..5.
- Back-to-back throughput:
  - Stimulus: alternate east/west packets every cycle for 20 cycles with ren_* held high.
  - Response: din_full never asserts; all 20 packets arrive in order per direction.
- Overflow and reset:
  - Stimulus: with din_full=1, assert din_wen with a distinct packet.
  - Response: overflow=1 and the packet never appears at any output. Then assert rst for 1 cycle mid-stream: all empty_*=1, din_full=0, overflow=0 next edge.
- Stats (FROM_LOCAL_XY_STATS_EN):
  - Stimulus: 3 north packets, 1 drop, then stat_clr together with a 4th north drain.
  - Response: cnt_north=3 and cnt_drop=1 before the clear; all counters 0 after.
